conv_result_reader: RTL
=======================

# conv_result_reader

Streams a finished convolution result buffer out of the convolution engine's result RAM. After the engine writes the output matrix row-major into RAM, this block reads it back in order over a synchronous read port. It emits one element per beat on a valid/ready stream, tagged with row/column indices and end-of-row/end-of-matrix flags. It sits between the convolution result memory and any downstream consumer: DMA, bus bridge or next layer.

## Interface
- DATA_W, 32, element width
- DIM_W, 10, width of every dimension and index
- ADDR_W, 20, result RAM address width (≥ 2·DIM_W)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; dimensions sampled with it
- in_rows, in_cols  in  DIM_W each  input matrix dimensions
- flt_rows, flt_cols  in  DIM_W each  filter dimensions
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky bad-dimension flag, cleared by next accepted start
- mem_rd_en  out  1  RAM read strobe
- mem_rd_addr  out  ADDR_W  RAM word address
- mem_rd_data  in  DATA_W  RAM data, valid exactly one cycle after mem_rd_en
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_data  out  DATA_W  element
- m_row, m_col  out  DIM_W each  element indices
- m_last_col  out  1  last element of a row
- m_last  out  1  last element of the matrix

## Operation
- Output size: out_rows = in_rows − flt_rows + 1, out_cols = in_cols − flt_cols + 1. Valid stride, no padding.
- Bad dimensions: any dimension zero, flt_rows > in_rows, or flt_cols > in_cols.
  - err = 1, no reads issued, done pulses the cycle after start.
- Address generation: row-major, addr = r·out_cols + c. Computed incrementally with an address counter; no multiplier.
- FSM states:
  - IDLE: start accepted; go to RUN, or DONE if dimensions are bad.
  - RUN: issue reads until the last address is issued.
  - DRAIN: wait until the FIFO is empty and no read is in flight.
  - DONE: done = 1 for one cycle, then IDLE.
- start outside IDLE is ignored; latched dimensions are unaffected.
- Buffering: 2-entry output FIFO.
  - A read is issued only when fifo_count + inflight − pop < 2, so RAM data always has a slot.
  - Returned data is never dropped or stalled.
- Stream rules:
  - m_valid stays high until handshake (m_valid & m_ready).
  - m_data, m_row, m_col and flags are held stable while m_valid is high and m_ready is low.
- Index counters wrap: c returns to 0 and r increments after c = out_cols−1. m_last = (r = out_rows−1 && c = out_cols−1).
- Reset values: busy, done, err, mem_rd_en, m_valid, m_last, m_last_col = 0; mem_rd_addr, m_data, m_row, m_col = 0; FSM = IDLE; FIFO empty.
- Reset mid-transfer: the in-flight read is discarded and the FIFO is flushed. No done pulse; the next start begins from address 0.

## Timing
- Cycle 0: start sampled. Cycle 1: busy = 1, first mem_rd_en with addr 0. Cycle 2: mem_rd_data valid. Cycle 3: first m_valid.
- With m_ready held high: one beat per cycle; an N-element matrix's last beat is at cycle N+2.
- done pulses the cycle after the m_last handshake; busy drops in that same cycle.
- After a stall of k cycles, the stream restarts with m_valid at most one cycle after m_ready rises; no bubble if the FIFO holds 2.

## Structure
- Shared package conv_pkg: DATA_W, DIM_W and ADDR_W defaults, FSM state encoding, and the output-dimension function. The package is shared with the convolution engine.
- Sub-module conv_rd_fifo: 2-entry synchronous FIFO with count output, async active-high reset, and no overflow by construction.
- Top level: FSM, address/index counters, in-flight tracking.

## Test plan
- 4×4 input, 3×3 filter, RAM[i] = 100+i, m_ready = 1 → addrs 0..3; beats 100/(0,0), 101/(0,1) m_last_col, 102/(1,0), 103/(1,1) m_last; done at cycle 7.
- 6×5 input, 2×2 filter (5×4 = 20 elements), m_ready toggling 1-0-1-1-0 → all 20 beats in order; data stable during stalls; FIFO never overflows; no read issued while 2 slots are committed.
- flt_rows = 5, in_rows = 4 → err = 1, done at cycle 1, mem_rd_en never asserted; next valid start clears err.
- 1×5 input, 1×1 filter → 5 beats, m_last_col only on col 4, simultaneous with m_last.
- rst asserted mid-RUN on 8×8 / 3×3 with m_ready = 0 → all outputs return to reset values immediately; restart reads from addr 0; no stale beat emitted.
- start pulsed again during RUN with different dimensions → ignored; original transfer completes unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine and its result reader:
// default widths, reader FSM encoding and output-dimension helpers.
package conv_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DIM_W  = 10;
  localparam int DEF_ADDR_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } conv_rd_state_e;

  // Valid-stride, unpadded convolution output size along one axis.
  function automatic int unsigned out_dim(input int unsigned in_dim,
                                          input int unsigned flt_dim);
    return in_dim - flt_dim + 1;
  endfunction

  // A dimension set is usable when nothing is zero and the filter fits.
  function automatic logic dims_valid(input int unsigned in_r,
                                      input int unsigned in_c,
                                      input int unsigned f_r,
                                      input int unsigned f_c);
    return (in_r != 0) && (in_c != 0) && (f_r != 0) && (f_c != 0) &&
           (f_r <= in_r) && (f_c <= in_c);
  endfunction

endpackage

// File: rtl/conv_rd_fifo.sv
// Two-entry output FIFO for the result reader. The producer never pushes
// into a full FIFO, so there is no overflow handling here. The head entry
// is presented combinationally and stays put until popped.
module conv_rd_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o,
  output logic         empty_o
);

  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         pop_ok;
  logic [W-1:0] slot_data [2];

  // Popping an empty FIFO is a no-op so the pointers can never skew.
  assign pop_ok = pop_i && (count_q != 2'd0);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      logic [W-1:0] slot_q;

      // Slot captures pushed data when the write pointer selects it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_q <= '0;
        end else if (push_i && (wr_ptr_q == 1'(gi))) begin
          slot_q <= push_data_i;
        end
      end

      assign slot_data[gi] = slot_q;
    end
  endgenerate

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = slot_data[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/conv_result_reader.sv
// Reads a finished convolution output matrix row-major out of the result
// RAM and streams it on a valid/ready interface with row/column tags.
// A read is only issued when the 2-entry FIFO is guaranteed a free slot
// for its data, so returning RAM data is never stalled or dropped.
module conv_result_reader
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM_W  = DEF_DIM_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  in_rows,
  input  logic [DIM_W-1:0]  in_cols,
  input  logic [DIM_W-1:0]  flt_rows,
  input  logic [DIM_W-1:0]  flt_cols,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [DIM_W-1:0]  m_row,
  output logic [DIM_W-1:0]  m_col,
  output logic              m_last_col,
  output logic              m_last
);

  localparam int FIFO_W = DATA_W + 2 * DIM_W + 2;
  localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  conv_rd_state_e state_q;

  logic [DIM_W-1:0]  out_rows_q;
  logic [DIM_W-1:0]  out_cols_q;
  logic [DIM_W-1:0]  rd_row_q;
  logic [DIM_W-1:0]  rd_col_q;
  logic [DIM_W-1:0]  rd_row_d;
  logic [DIM_W-1:0]  rd_col_d;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  // Tags of the read currently in flight, paired with its data next cycle.
  logic              rd_pend_q;
  logic [DIM_W-1:0]  pend_row_q;
  logic [DIM_W-1:0]  pend_col_q;
  logic              pend_last_col_q;
  logic              pend_last_q;

  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_head;
  logic [FIFO_W-1:0] fifo_wdata;

  logic              pop;
  logic              issue;
  logic              credit_ok;
  logic [2:0]        committed;
  logic              rd_last_col;
  logic              rd_last;
  logic              drain_empty;
  logic              start_bad;
  logic [DIM_W-1:0]  new_out_rows;
  logic [DIM_W-1:0]  new_out_cols;

  assign start_bad    = !dims_valid(32'(in_rows), 32'(in_cols),
                                    32'(flt_rows), 32'(flt_cols));
  assign new_out_rows = DIM_W'(out_dim(32'(in_rows), 32'(flt_rows)));
  assign new_out_cols = DIM_W'(out_dim(32'(in_cols), 32'(flt_cols)));

  assign pop = m_valid && m_ready;

  // Slots already promised: FIFO contents plus the read whose data is due.
  assign committed = {1'b0, fifo_count} + {2'b00, rd_pend_q};
  assign credit_ok = (committed - {2'b00, pop}) < 3'd2;
  assign issue     = (state_q == ST_RUN) && credit_ok;

  assign rd_last_col = (rd_col_q == (out_cols_q - DIM_ONE));
  assign rd_last     = rd_last_col && (rd_row_q == (out_rows_q - DIM_ONE));

  // Everything is out once the FIFO empties this cycle with nothing pending.
  assign drain_empty = (fifo_count == {1'b0, pop}) && !rd_pend_q;

  // Row/column indices of the next read; column wraps into the next row.
  always_comb begin
    rd_col_d = rd_col_q + DIM_ONE;
    rd_row_d = rd_row_q;
    if (rd_last_col) begin
      rd_col_d = '0;
      rd_row_d = rd_row_q + DIM_ONE;
    end
  end

  // Control FSM with registered busy/done/err and the read address counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_rows_q <= '0;
      out_cols_q <= '0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            out_rows_q <= new_out_rows;
            out_cols_q <= new_out_cols;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            addr_q     <= '0;
            err_q      <= start_bad;
            if (start_bad) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr_q   <= addr_q + ADDR_ONE;
            rd_row_q <= rd_row_d;
            rd_col_q <= rd_col_d;
            if (rd_last) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_empty) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Carry the issued read's tags forward to meet its data one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q       <= 1'b0;
      pend_row_q      <= '0;
      pend_col_q      <= '0;
      pend_last_col_q <= 1'b0;
      pend_last_q     <= 1'b0;
    end else begin
      rd_pend_q <= issue;
      if (issue) begin
        pend_row_q      <= rd_row_q;
        pend_col_q      <= rd_col_q;
        pend_last_col_q <= rd_last_col;
        pend_last_q     <= rd_last;
      end
    end
  end

  assign fifo_wdata = {pend_last_q, pend_last_col_q, pend_row_q, pend_col_q, mem_rd_data};

  conv_rd_fifo #(
    .W(FIFO_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rd_pend_q),
    .push_data_i (fifo_wdata),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_q;
  assign m_valid     = !fifo_empty;
  assign {m_last, m_last_col, m_row, m_col, m_data} = fifo_head;

endmodule
